// File: rtl/button_conditioner.sv
// Button front-end: 2-flop sync, debounce, one-cycle press pulse per bit.
// Define BUTTON_AUTO_REPEAT_EN to build hold-to-repeat pulsing (gated by REPEAT_MASK).
module button_conditioner #(
    parameter int unsigned        NUM_BTN           = 5,
    parameter int unsigned        DB_CYCLES         = 251_750,
    parameter int unsigned        RPT_DELAY_CYCLES  = 12_587_500,
    parameter int unsigned        RPT_PERIOD_CYCLES = 2_517_500,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK       = NUM_BTN'(5'b01111)
) (
    input  logic               video_clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse
);

    localparam int unsigned     DbW    = $clog2(DB_CYCLES + 1);
    localparam logic [DbW-1:0]  DbLast = DbW'(DB_CYCLES - 1);

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int unsigned     TmMax      = (RPT_DELAY_CYCLES > RPT_PERIOD_CYCLES) ?
                                             RPT_DELAY_CYCLES : RPT_PERIOD_CYCLES;
    localparam int unsigned     TmW        = $clog2(TmMax + 1);
    localparam logic [TmW-1:0]  DelayLast  = TmW'(RPT_DELAY_CYCLES - 1);
    localparam logic [TmW-1:0]  PeriodLast = TmW'(RPT_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StHold, StRpt} state_e;
`else
    typedef enum logic [0:0] {StIdle, StHold} state_e;

    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_MASK, RPT_DELAY_CYCLES[0], RPT_PERIOD_CYCLES[0]};
`endif

    logic [NUM_BTN-1:0] sync_q1;
    logic [NUM_BTN-1:0] sync_q2;

    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [DbW-1:0] db_cnt_q;
        logic           level_q;
        logic           pulse_q;
        logic           accept;
        logic           rise;
        state_e         state_q;

        // The level only moves once the synced input has disagreed for DB_CYCLES cycles.
        assign accept = (sync_q2[i] != level_q) && (db_cnt_q == DbLast);
        assign rise   = accept && sync_q2[i];

        always_ff @(posedge video_clk or negedge reset_n) begin
            if (!reset_n) begin
                db_cnt_q <= '0;
                level_q  <= 1'b0;
            end else if (sync_q2[i] == level_q) begin
                db_cnt_q <= '0;
            end else if (accept) begin
                level_q  <= sync_q2[i];
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end

`ifdef BUTTON_AUTO_REPEAT_EN
        localparam bit RptEn = REPEAT_MASK[i];
        logic [TmW-1:0] timer_q;

        always_ff @(posedge video_clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= StIdle;
                timer_q <= '0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                case (state_q)
                    // Pulse lands in the same cycle the debounced level first reads 1.
                    StIdle: begin
                        if (rise) begin
                            pulse_q <= 1'b1;
                            timer_q <= '0;
                            state_q <= StHold;
                        end
                    end
                    StHold: begin
                        if (!level_q) begin
                            timer_q <= '0;
                            state_q <= StIdle;
                        end else if (!RptEn) begin
                            timer_q <= '0;
                        end else if (timer_q == DelayLast) begin
                            pulse_q <= 1'b1;
                            timer_q <= '0;
                            state_q <= StRpt;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    StRpt: begin
                        if (!level_q) begin
                            timer_q <= '0;
                            state_q <= StIdle;
                        end else if (timer_q == PeriodLast) begin
                            pulse_q <= 1'b1;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    default: begin
                        timer_q <= '0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
`else
        always_ff @(posedge video_clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= StIdle;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                case (state_q)
                    StIdle: begin
                        if (rise) begin
                            pulse_q <= 1'b1;
                            state_q <= StHold;
                        end
                    end
                    StHold: begin
                        if (!level_q) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
`endif

        assign btn_level[i] = level_q;
        assign btn_pulse[i] = pulse_q;
    end

endmodule
